branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Program-counter and branch-resolution stage that sits directly around the condition checker.
- Holds and advances the fetch PC.
- Accepts conditional branches from decode and drives the condition code into the checker.
- Consumes the checker's registered `Ok` result, then redirects the PC with a one-cycle flush or resumes sequential fetch.

Parameters:
- PC_WIDTH, 32: width of PC, branch address and target arithmetic.
- OFFSET_WIDTH, 11: width of the signed branch offset, in halfword units.
- RESET_PC, 0: PC value loaded on reset.
- INSTR_BYTES, 2: PC increment per sequential advance.

Ports:
- clk  input  1  single clock, rising edge.
- not_reset  input  1  synchronous, active-low reset.
- advance  input  1  fetch consumed current pc; step pc.
- br_valid  input  1  decode presents a branch.
- br_ready  output  1  branch can be accepted this cycle.
- br_cond  input  4  condition code (0000 EQ … 1110 AL, 1111 reserved).
- br_pc  input  PC_WIDTH  address of the branch instruction.
- br_offset  input  OFFSET_WIDTH  signed offset, halfwords.
- chk_cond  output  4  condition code driven into the checker.
- chk_not_enable  output  1  checker disable; 1 forces the checker's Ok to 0.
- chk_ok  input  1  registered condition-true result from the checker.
- pc  output  PC_WIDTH  current fetch address.
- pc_valid  output  1  pc may be fetched.
- flush  output  1  one-cycle pulse: discard fetched/decoded instructions.
- br_taken  output  1  one-cycle pulse: branch resolved taken.
- br_done  output  1  one-cycle pulse: branch resolved (taken or not).

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-low on `not_reset`, sampled at the rising edge of `clk`. All registers are clocked.
- Reset values:
  - state = RUN, pc = RESET_PC, chk_cond = 0000, chk_not_enable = 1.
  - flush = br_taken = br_done = 0.
  - Latched condition, target and skip flag are cleared.
  - Reset mid-branch discards the pending branch; no pulses are produced.
  - Holding chk_not_enable = 1 during reset clears the checker's Ok after one edge.
- Derived outputs: br_ready = pc_valid = (state == RUN), combinational from state.
- Target = br_pc + 4 + (sign_extend(br_offset) << 1), computed at acceptance, modulo 2^PC_WIDTH (wrap, no overflow flag).
- State RUN:
  - If br_valid && br_ready: latch target; chk_cond <= br_cond; chk_not_enable <= (br_cond == 1111); skip <= (br_cond == 1111); next state CHECK.
  - A branch has priority over advance in the same cycle; pc does not step that cycle.
  - Otherwise, if advance: pc <= pc + INSTR_BYTES (wraps).
- State CHECK (1 cycle):
  - The checker samples chk_cond at the closing edge.
  - chk_not_enable <= 1; next state RESOLVE.
  - advance and br_valid are ignored.
- State RESOLVE (1 cycle):
  - taken = chk_ok && !skip. Code 1111 is always not-taken because the checker has no case for it and would hold a stale Ok.
  - If taken: pc <= target, flush <= 1, br_taken <= 1.
  - Otherwise: pc is unchanged.
  - In both cases br_done <= 1; next state RUN.
- Pulses: flush, br_taken and br_done are high for exactly one cycle after the RESOLVE edge, then return to 0.
- Latency: accept edge E0 → resolution visible after E2. br_ready is low for 2 cycles per branch; back-to-back branches are accepted every 3 cycles.
- A branch with br_cond = 1110 is always taken via chk_ok = 1.
- chk_cond holds its last value while idle; only chk_not_enable gates the checker.

Test Plan:
1. Reset/advance: not_reset = 0 for 2 cycles, then advance = 1 for 3 cycles → pc: 0 → 2 → 4 → 6. pc_valid = 1 and br_ready = 1 throughout.
2. Taken EQ:
   - Stimulus: at pc = 0x10, br_pc = 0x10, br_cond = 0000, br_offset = 11'h008; checker model fed flags Z = 1.
   - Required: chk_not_enable = 0 for one cycle; br_ready low for 2 cycles; after E2, pc = 0x24, flush = br_taken = br_done = 1 for one cycle.
3. Not taken / negative offset:
   - Stimulus: br_cond = 0001 with Z = 1, br_offset = 11'h7FE (−2).
   - Required: pc holds, flush = 0, br_taken = 0, br_done = 1 for one cycle.
4. Reserved code and priority:
   - Stimulus: br_cond = 1111 with chk_ok forced to 1; simultaneously advance = 1 on the accept cycle.
   - Required: chk_not_enable stays 1, pc does not step, result is not-taken, br_done pulses.
5. Wrap:
   - br_pc = 0xFFFF_FFFC, offset = +2, cond 1110 → pc = 0x0000_0004.
   - Separately, pc = 0xFFFF_FFFE with advance → pc = 0.
6. Reset mid-operation: assert not_reset = 0 during CHECK → next cycle state RUN, pc = RESET_PC, no flush/br_taken/br_done pulse, chk_not_enable = 1.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Fetch PC holder and conditional-branch resolver wrapped around an external
// registered condition checker: accept -> check -> resolve, then redirect or resume.
module branch_pc_unit #(
    parameter int          PC_WIDTH     = 32,
    parameter int          OFFSET_WIDTH = 11,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned INSTR_BYTES  = 2
) (
    input  logic                    clk,
    input  logic                    not_reset,
    input  logic                    advance,
    input  logic                    br_valid,
    output logic                    br_ready,
    input  logic [3:0]              br_cond,
    input  logic [PC_WIDTH-1:0]     br_pc,
    input  logic [OFFSET_WIDTH-1:0] br_offset,
    output logic [3:0]              chk_cond,
    output logic                    chk_not_enable,
    input  logic                    chk_ok,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    pc_valid,
    output logic                    flush,
    output logic                    br_taken,
    output logic                    br_done
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_CHECK   = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] RESET_PC_W = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] STEP_W     = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] FOUR_W     = PC_WIDTH'(4);
    localparam logic [3:0]          COND_RSVD  = 4'b1111;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   target_q, target_d;
    logic [3:0]            cond_q, cond_d;
    logic                  not_en_q, not_en_d;
    logic                  skip_q, skip_d;
    logic                  flush_q, flush_d;
    logic                  taken_q, taken_d;
    logic                  done_q, done_d;

    logic [PC_WIDTH-1:0]   offset_ext_s;
    logic [PC_WIDTH-1:0]   target_s;

    // Offset counts halfwords relative to the branch address plus four.
    assign offset_ext_s = {{(PC_WIDTH-OFFSET_WIDTH){br_offset[OFFSET_WIDTH-1]}}, br_offset};
    assign target_s     = br_pc + FOUR_W + (offset_ext_s << 1);

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        cond_d   = cond_q;
        not_en_d = not_en_q;
        skip_d   = skip_q;
        flush_d  = 1'b0;
        taken_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (br_valid) begin
                    target_d = target_s;
                    cond_d   = br_cond;
                    not_en_d = (br_cond == COND_RSVD);
                    skip_d   = (br_cond == COND_RSVD);
                    state_d  = S_CHECK;
                end else if (advance) begin
                    pc_d = pc_q + STEP_W;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_CHECK: begin
                not_en_d = 1'b1;
                state_d  = S_RESOLVE;
            end
            S_RESOLVE: begin
                done_d  = 1'b1;
                state_d = S_RUN;
                // Reserved code never redirects: the checker would hold a stale Ok.
                if (chk_ok && !skip_q) begin
                    pc_d    = target_q;
                    flush_d = 1'b1;
                    taken_d = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!not_reset) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC_W;
            target_q <= '0;
            cond_q   <= 4'b0000;
            not_en_q <= 1'b1;
            skip_q   <= 1'b0;
            flush_q  <= 1'b0;
            taken_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            cond_q   <= cond_d;
            not_en_q <= not_en_d;
            skip_q   <= skip_d;
            flush_q  <= flush_d;
            taken_q  <= taken_d;
            done_q   <= done_d;
        end
    end

    assign br_ready       = (state_q == S_RUN);
    assign pc_valid       = (state_q == S_RUN);
    assign pc             = pc_q;
    assign chk_cond       = cond_q;
    assign chk_not_enable = not_en_q;
    assign flush          = flush_q;
    assign br_taken       = taken_q;
    assign br_done        = done_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with a cycle-level reference model and a
// small registered condition-checker model driving chk_ok.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        not_reset;
    logic        advance;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_pc;
    logic [10:0] br_offset;
    logic [3:0]  chk_cond;
    logic        chk_not_enable;
    logic        chk_ok;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        br_taken;
    logic        br_done;

    int checks = 0;
    int errors = 0;

    logic [3:0] flags = 4'b0000;   // {N, Z, C, V}
    logic       force_ok = 1'b0;
    logic       ok_q = 1'b0;

    branch_pc_unit dut (
        .clk(clk), .not_reset(not_reset), .advance(advance),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_pc(br_pc), .br_offset(br_offset), .chk_cond(chk_cond),
        .chk_not_enable(chk_not_enable), .chk_ok(chk_ok), .pc(pc),
        .pc_valid(pc_valid), .flush(flush), .br_taken(br_taken), .br_done(br_done)
    );

    always #5 clk = ~clk;

    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Checker model: registered Ok, cleared while disabled.
    always @(posedge clk) begin
        ok_q <= (chk_not_enable === 1'b0) ? cond_true(chk_cond, flags) : 1'b0;
    end
    assign chk_ok = force_ok | ok_q;

    // Reference model: a branch occupies the two cycles after acceptance and
    // its result appears on the third.
    int          m_busy = 0;
    logic        m_ok = 1'b0;
    logic [31:0] m_pc, m_target;
    logic        m_taken_pend, m_flush, m_taken, m_done, m_ne;
    logic [3:0]  m_cond;

    always @(posedge clk) begin
        if (!not_reset) begin
            m_ok    <= 1'b1;
            m_busy  <= 0;
            m_pc    <= 32'h0000_0000;
            m_cond  <= 4'b0000;
            m_ne    <= 1'b1;
            m_flush <= 1'b0;
            m_taken <= 1'b0;
            m_done  <= 1'b0;
        end else begin
            m_flush <= 1'b0;
            m_taken <= 1'b0;
            m_done  <= 1'b0;
            if (m_busy == 0) begin
                if (br_valid) begin
                    m_busy       <= 2;
                    m_target     <= 32'(longint'(br_pc) + 64'sd4 + 64'sd2 * longint'($signed(br_offset)));
                    m_taken_pend <= (br_cond != 4'b1111) && cond_true(br_cond, flags);
                    m_cond       <= br_cond;
                    m_ne         <= (br_cond == 4'b1111);
                end else if (advance) begin
                    m_pc <= m_pc + 32'd2;
                end
            end else if (m_busy == 2) begin
                m_busy <= 1;
                m_ne   <= 1'b1;
            end else begin
                m_busy <= 0;
                m_done <= 1'b1;
                if (m_taken_pend) begin
                    m_pc    <= m_target;
                    m_flush <= 1'b1;
                    m_taken <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            check("pc", pc, m_pc);
            check("pc_valid", {31'd0, pc_valid}, {31'd0, m_busy == 0});
            check("br_ready", {31'd0, br_ready}, {31'd0, m_busy == 0});
            check("flush", {31'd0, flush}, {31'd0, m_flush});
            check("br_taken", {31'd0, br_taken}, {31'd0, m_taken});
            check("br_done", {31'd0, br_done}, {31'd0, m_done});
            check("chk_not_enable", {31'd0, chk_not_enable}, {31'd0, m_ne});
            check("chk_cond", {28'd0, chk_cond}, {28'd0, m_cond});
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_branch(input logic [31:0] bpc, input logic [3:0] c,
                             input logic [10:0] off, input logic adv, input logic frc);
        step(1);
        br_valid = 1'b1; br_pc = bpc; br_cond = c; br_offset = off;
        advance = adv; force_ok = frc;
        step(1);
        br_valid = 1'b0; advance = 1'b0;
        step(2);
        force_ok = 1'b0;
    endtask

    initial begin
        not_reset = 1'b0; advance = 1'b0; br_valid = 1'b0;
        br_cond = 4'b0000; br_pc = 32'd0; br_offset = 11'd0;
        step(2);
        not_reset = 1'b1;
        check("reset_pc", pc, 32'h0000_0000);
        check("reset_ne", {31'd0, chk_not_enable}, 32'd1);

        // Sequential fetch 0 -> 2 -> 4 -> 6, then on to 0x10.
        advance = 1'b1;
        step(3);
        check("advance_pc", pc, 32'h0000_0006);
        step(5);
        advance = 1'b0;
        check("advance_pc_10", pc, 32'h0000_0010);

        // Taken EQ with Z set.
        flags = 4'b0100;
        do_branch(32'h10, 4'b0000, 11'h008, 1'b0, 1'b0);
        check("eq_taken_pc", pc, 32'h0000_0024);
        check("eq_taken_flush", {31'd0, flush}, 32'd1);
        check("eq_taken_done", {31'd0, br_done}, 32'd1);
        step(1);
        check("eq_flush_clear", {31'd0, flush}, 32'd0);

        // NE with Z set: not taken, negative offset.
        do_branch(32'h24, 4'b0001, 11'h7FE, 1'b0, 1'b0);
        check("ne_hold_pc", pc, 32'h0000_0024);
        check("ne_taken", {31'd0, br_taken}, 32'd0);
        check("ne_done", {31'd0, br_done}, 32'd1);

        // Reserved code with Ok forced and advance on accept cycle.
        do_branch(32'h24, 4'b1111, 11'h010, 1'b1, 1'b1);
        check("rsvd_pc", pc, 32'h0000_0024);
        check("rsvd_taken", {31'd0, br_taken}, 32'd0);
        check("rsvd_done", {31'd0, br_done}, 32'd1);

        // Target wrap and sequential wrap.
        do_branch(32'hFFFF_FFFC, 4'b1110, 11'h002, 1'b0, 1'b0);
        check("wrap_target", pc, 32'h0000_0004);
        do_branch(32'h0000_0000, 4'b1110, 11'h7FD, 1'b0, 1'b0);
        check("neg_target", pc, 32'hFFFF_FFFE);
        advance = 1'b1;
        step(1);
        advance = 1'b0;
        check("wrap_advance", pc, 32'h0000_0000);

        // Back-to-back requests: accepted every third cycle.
        flags = 4'b0000;
        br_valid = 1'b1; br_pc = 32'h100; br_cond = 4'b0001; br_offset = 11'h000;
        step(7);
        br_valid = 1'b0;
        step(3);
        check("b2b_pc", pc, 32'h0000_0104);

        // Reset while a branch sits in the check cycle.
        advance = 1'b1;
        step(2);
        advance = 1'b0;
        br_valid = 1'b1; br_pc = 32'h200; br_cond = 4'b1110; br_offset = 11'h010;
        step(1);
        br_valid = 1'b0;
        not_reset = 1'b0;
        step(1);
        check("midrst_pc", pc, 32'h0000_0000);
        check("midrst_ready", {31'd0, br_ready}, 32'd1);
        check("midrst_ne", {31'd0, chk_not_enable}, 32'd1);
        not_reset = 1'b1;
        step(2);
        check("midrst_no_done", {31'd0, br_done}, 32'd0);
        check("midrst_no_flush", {31'd0, flush}, 32'd0);
        check("midrst_pc_after", pc, 32'h0000_0000);

        step(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
